ym_clkgen2ph: RTL and testbench

YM_CLKGEN2PH -- requirements
Module: ym_clkgen2ph

---
 rtl/ym_clkgen2ph.sv | 118 +++++++++++
 tb/tb_ym_clkgen2ph.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ym_clkgen2ph.sv
// Two-phase non-overlapping clock generator with slot counter.
// c1/c2 come straight from flops so downstream latches see clean edges.
module ym_clkgen2ph #(
  parameter int DIV_WIDTH  = 4,
  parameter int GAP        = 1,
  parameter int SLOTS      = 24,
  parameter int SLOT_WIDTH = 5
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DIV_WIDTH-1:0]  div,
  output logic                  c1,
  output logic                  c2,
  output logic [SLOT_WIDTH-1:0] slot,
  output logic                  sync,
  output logic                  running
);

  localparam int CW = (DIV_WIDTH > 3) ? DIV_WIDTH : 3;

  typedef enum logic [2:0] {
    IDLE, PH1, GAP1, PH2, GAP2
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DIV_WIDTH-1:0]  div_q, div_q_n, div_eff;
  logic [SLOT_WIDTH-1:0] slot_n;
  logic                  sync_n;
  logic                  wrap;

  assign div_eff = (div == '0) ? DIV_WIDTH'(1) : div;
  assign wrap    = (slot == SLOT_WIDTH'(SLOTS - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_q_n = div_q;
    slot_n  = slot;
    sync_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_n = PH1;
          div_q_n = div_eff;
          cnt_n   = CW'(div_eff) - CW'(1);
        end
      end
      PH1: begin
        if (cnt == '0) begin
          state_n = GAP1;
          cnt_n   = CW'(GAP - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP1: begin
        if (cnt == '0) begin
          state_n = PH2;
          cnt_n   = CW'(div_q) - CW'(1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      PH2: begin
        if (cnt == '0) begin
          state_n = GAP2;
          cnt_n   = CW'(GAP - 1);
          slot_n  = wrap ? '0 : slot + SLOT_WIDTH'(1);
          sync_n  = wrap;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP2: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (en) begin
          state_n = PH1;
          div_q_n = div_eff;
          cnt_n   = CW'(div_eff) - CW'(1);
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= DIV_WIDTH'(1);
      slot    <= '0;
      sync    <= 1'b0;
      c1      <= 1'b0;
      c2      <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_q   <= div_q_n;
      slot    <= slot_n;
      sync    <= sync_n;
      c1      <= (state_n == PH1);
      c2      <= (state_n == PH2);
      running <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_ym_clkgen2ph.sv
// Randomized bench for ym_clkgen2ph against a phase-schedule model.
// The model expands each started cycle into a per-MCLK output list.
module tb_ym_clkgen2ph;

  localparam int DW  = 4;
  localparam int G   = 1;
  localparam int NS  = 4;
  localparam int SW  = 5;

  logic          MCLK = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] div = '0;
  logic          c1, c2, sync, running;
  logic [SW-1:0] slot;

  ym_clkgen2ph #(
    .DIV_WIDTH(DW), .GAP(G), .SLOTS(NS), .SLOT_WIDTH(SW)
  ) dut (
    .MCLK(MCLK), .reset(reset), .en(en), .div(div),
    .c1(c1), .c2(c2), .slot(slot), .sync(sync),
    .running(running)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, got, exp);
    end
  endtask

  // Model: queue of {c1,c2,slot_step} per MCLK cycle of a started period.
  logic [2:0] q[$];
  int  m_slot = 0;
  bit  m_sync = 0, e_c1 = 0, e_c2 = 0, e_run = 0;
  int  cyc = 0, sync_count = 0;
  int  rises[$];
  bit  pc1 = 0;

  task automatic model_step();
    logic [2:0] e;
    int d;
    if (!reset) begin
      q.delete();
      m_slot = 0; m_sync = 0;
      e_c1 = 0; e_c2 = 0; e_run = 0;
      return;
    end
    if (q.size() == 0 && en) begin
      d = (div == 0) ? 1 : int'(div);
      for (int i = 0; i < d; i++) q.push_back(3'b100);
      for (int i = 0; i < G; i++) q.push_back(3'b000);
      for (int i = 0; i < d; i++) q.push_back(3'b010);
      for (int i = 0; i < G; i++)
        q.push_back(i == 0 ? 3'b001 : 3'b000);
    end
    m_sync = 0;
    if (q.size() != 0) begin
      e = q.pop_front();
      e_c1 = e[2]; e_c2 = e[1]; e_run = 1;
      if (e[0]) begin
        m_sync = (m_slot == NS - 1);
        m_slot = (m_slot + 1) % NS;
      end
    end else begin
      e_c1 = 0; e_c2 = 0; e_run = 0;
    end
  endtask

  initial forever begin
    @(posedge MCLK);
    cyc++;
    model_step();
    #1;
    chk("c1", c1, e_c1);
    chk("c2", c2, e_c2);
    chk("slot", slot, m_slot);
    chk("sync", sync, m_sync);
    chk("running", running, e_run);
    if (sync) sync_count++;
    if (c1 && !pc1) rises.push_back(cyc);
    pc1 = c1;
  end

  time tpos = 0;
  initial forever begin
    @(posedge MCLK);
    tpos = $time;
  end

  initial forever begin
    @(c1 or c2);
    checks++;
    if (c1 && c2) begin
      errors++;
      $display("FAIL overlap got c1=%0d c2=%0d expected not both", c1, c2);
    end
    if (reset && $time != tpos) begin
      errors++;
      $display("FAIL edge_only got change at %0t expected at %0t", $time, tpos);
    end
  end

  // 0: wait c1 rise; 1: wait c2 rise with slot==3
  task automatic wait_for(input int what, input int lim);
    bit p1 = c1, p2 = c2, hit = 0;
    for (int i = 0; i < lim && !hit; i++) begin
      @(posedge MCLK);
      #2;
      if (what == 0) hit = c1 && !p1;
      else hit = c2 && !p2 && slot == 3;
      p1 = c1; p2 = c2;
    end
    if (!hit) chk("wait_timeout", 0, 1);
  endtask

  initial begin
    #1;
    chk("rst_c1", c1, 0);
    chk("rst_c2", c2, 0);
    chk("rst_slot", slot, 0);
    chk("rst_sync", sync, 0);
    chk("rst_run", running, 0);

    // div=2 from reset: period 6, first wrap at 4th PH2 end
    @(negedge MCLK);
    div = 2; en = 1; reset = 1;
    repeat (30) @(posedge MCLK);
    #2;
    chk("s1_slot", slot, 1);
    chk("s1_sync_count", sync_count, 1);
    chk("s1_gap2", {c1, c2}, 0);
    chk("s1_period", rises[$] - rises[$-1], 6);

    // div 2->4 during PH1
    wait_for(0, 40);
    begin
      int ra;
      ra = rises[$];
      @(negedge MCLK);
      div = 4;
      wait_for(0, 40);
      wait_for(0, 40);
      chk("s2_old_period", rises[$-1] - ra, 6);
      chk("s2_new_period", rises[$] - rises[$-1], 10);
    end

    // div=0 acts as 1
    @(negedge MCLK);
    div = 0;
    repeat (3) wait_for(0, 40);
    chk("s3_period", rises[$] - rises[$-1], 4);

    // en dropped mid PH1
    wait_for(0, 40);
    @(negedge MCLK);
    en = 0;
    repeat (20) @(posedge MCLK);
    #2;
    chk("s4_idle_run", running, 0);
    chk("s4_idle_c", {c1, c2}, 0);
    @(negedge MCLK);
    en = 1;
    @(posedge MCLK);
    #2;
    chk("s4_restart_c1", c1, 1);

    // async reset mid PH2 at slot 3
    wait_for(1, 100);
    #1;
    reset = 0;
    #1;
    chk("s6_c2_async", c2, 0);
    chk("s6_slot", slot, 0);
    chk("s6_run", running, 0);
    @(negedge MCLK);
    @(negedge MCLK);
    reset = 1;
    @(posedge MCLK);
    #2;
    chk("s6_resume_c1", c1, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge MCLK);
      en  = ($urandom_range(0, 9) != 0);
      div = DW'($urandom_range(0, 15));
      reset = ($urandom_range(0, 149) != 0);
    end
    @(negedge MCLK);
    reset = 1;
    repeat (4) @(posedge MCLK);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

endmodule
